uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one serial UART link between `numReq` requesters. It accepts a `packetSize`-bit word from the granted requester and drives the link-side `recSig` announce pulse. It then waits the 3-bit-period lead-in that the receive FSM requires and serializes the word MSB-first on `bsOut`, with its own bit-period divider. It sits between local packet producers and the serial link into a `UART_Rec` instance.

---
 rtl/uart_tx_sched_if.sv | 27 ++
 rtl/uart_tx_sched.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester/link bundle for uart_tx_sched.
// master: packet producers plus link observer; slave: the scheduler itself.
interface uart_tx_sched_if #(
  parameter int packetSize = 4,
  parameter int numReq     = 3
);
  localparam int IDX_W = $clog2(numReq);

  logic [numReq-1:0]            req;
  logic [numReq*packetSize-1:0] dataIn;
  logic [numReq-1:0]            ack;
  logic [IDX_W-1:0]             grantIdx;
  logic                         busy;
  logic                         done;
  logic                         recSig;
  logic                         bsOut;

  modport master (
    output req, dataIn,
    input  ack, grantIdx, busy, done, recSig, bsOut
  );

  modport slave (
    input  req, dataIn,
    output ack, grantIdx, busy, done, recSig, bsOut
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one serial UART link.
// Sequence per packet: SIG (recSig, 1 period), LEAD (3 periods of 0),
// DATA (MSB first), optional PAR, GAP (1 period of 0), then IDLE with done.
// Optional feature macro: UART_SCHED_PARITY_EN adds an even-parity bit
// period after DATA.
module uart_tx_sched #(
  parameter int packetSize = 4,
  parameter int cycleDiv   = 100,
  parameter int numReq     = 3
) (
  input logic             clk,
  input logic             rstN,
  uart_tx_sched_if.slave  bus
);
  localparam int IDX_W = $clog2(numReq);
  localparam int TW    = $clog2(cycleDiv);
  localparam int BW    = $clog2(packetSize + 4);

`ifdef UART_SCHED_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, SIG = 3'd1, LEAD = 3'd2, DATA = 3'd3, PAR = 3'd4, GAP = 3'd5
  } state_t;

  function automatic logic even_parity(input logic [packetSize-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, SIG = 3'd1, LEAD = 3'd2, DATA = 3'd3, GAP = 3'd5
  } state_t;
`endif

  state_t                  state_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        grant_q;
  logic [packetSize-1:0]   sh_q;
  logic [TW-1:0]           tick_q;
  logic [BW-1:0]           bit_q;
  logic [numReq-1:0]       ack_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    rec_q;
  logic                    bs_q;
`ifdef UART_SCHED_PARITY_EN
  logic                    par_q;
`endif

  logic                    win_found_s;
  logic [IDX_W-1:0]        win_idx_s;
  logic [IDX_W:0]          cand_s;
  logic [numReq-1:0]       ack_hot_s;
  logic [packetSize-1:0]   slice_s;
  logic [packetSize-1:0]   sh_next_s;
  logic                    tick_end_s;

  assign tick_end_s = (tick_q == TW'(cycleDiv - 1));
  assign sh_next_s  = sh_q << 1'b1;

  // Round-robin search: first set request starting at ptr+1, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= numReq; k++) begin
      cand_s = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand_s >= (IDX_W+1)'(numReq)) begin
        cand_s = cand_s - (IDX_W+1)'(numReq);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && bus.req[cand_s[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the winner's packet slice and build its one-hot ack.
  always_comb begin
    slice_s   = '0;
    ack_hot_s = '0;
    for (int i = 0; i < numReq; i++) begin
      if (win_idx_s == IDX_W'(i)) begin
        slice_s      = bus.dataIn[i*packetSize +: packetSize];
        ack_hot_s[i] = 1'b1;
      end else begin
        ack_hot_s[i] = 1'b0;
      end
    end
  end

  // Link FSM: arbitration, bit-period timing and registered outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(numReq - 1);
      grant_q <= '0;
      sh_q    <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rec_q   <= 1'b0;
      bs_q    <= 1'b0;
`ifdef UART_SCHED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found_s) begin
            ack_q   <= ack_hot_s;
            sh_q    <= slice_s;
            grant_q <= win_idx_s;
            ptr_q   <= win_idx_s;
            tick_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            rec_q   <= 1'b1;
            bs_q    <= 1'b0;
`ifdef UART_SCHED_PARITY_EN
            par_q   <= even_parity(slice_s);
`endif
            state_q <= SIG;
          end
        end
        SIG: begin
          if (tick_end_s) begin
            tick_q  <= '0;
            rec_q   <= 1'b0;
            bit_q   <= '0;
            state_q <= LEAD;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        LEAD: begin
          if (tick_end_s) begin
            tick_q <= '0;
            if (bit_q == BW'(2)) begin
              bit_q   <= '0;
              bs_q    <= sh_q[packetSize-1];
              state_q <= DATA;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_end_s) begin
            tick_q <= '0;
            sh_q   <= sh_next_s;
            bit_q  <= bit_q + BW'(1);
            if (bit_q == BW'(packetSize - 1)) begin
`ifdef UART_SCHED_PARITY_EN
              bs_q    <= par_q;
              state_q <= PAR;
`else
              bs_q    <= 1'b0;
              state_q <= GAP;
`endif
            end else begin
              bs_q <= sh_next_s[packetSize-1];
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
`ifdef UART_SCHED_PARITY_EN
        PAR: begin
          if (tick_end_s) begin
            tick_q  <= '0;
            bs_q    <= 1'b0;
            state_q <= GAP;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
`endif
        GAP: begin
          if (tick_end_s) begin
            tick_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= '0;
          busy_q  <= 1'b0;
          rec_q   <= 1'b0;
          bs_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grantIdx = grant_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.recSig   = rec_q;
  assign bus.bsOut    = bs_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (packetSize=4, cycleDiv=10, numReq=3).
// Expected link waveform is derived from the cycle offset after ack.
module tb_uart_tx_sched;
  localparam int PS = 4;
  localparam int CD = 10;
  localparam int NR = 3;
`ifdef UART_SCHED_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int DUR = (5 + PS) * CD + (PAR_EN ? CD : 0);

  logic clk;
  logic rstN;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_ack = 0;

  uart_tx_sched_if #(.packetSize(PS), .numReq(NR)) bus ();

  uart_tx_sched #(.packetSize(PS), .cycleDiv(CD), .numReq(NR)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for ack spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, bus.ack, bus.grantIdx, bus.recSig, bus.bsOut, bus.busy, bus.done};
  endfunction

  // Expected {ack, grantIdx, recSig, bsOut, busy, done} at offset c from ack.
  function automatic logic [31:0] exp_wave(input int c, input int idx, input logic [PS-1:0] d);
    logic [2:0]    a;
    logic          rec, bs, bsy, dn;
    logic [PS-1:0] tmp;
    a   = (c == 0) ? (3'b001 << idx) : 3'b000;
    rec = (c < CD);
    bs  = 1'b0;
    if (c >= 4*CD && c < (4+PS)*CD) begin
      tmp = d >> (PS - 1 - (c - 4*CD) / CD);
      bs  = tmp[0];
    end else if (PAR_EN && c >= (4+PS)*CD && c < (5+PS)*CD) begin
      bs = ^d;
    end
    bsy = (c < DUR);
    dn  = (c == DUR);
    return {23'd0, a, 2'(idx), rec, bs, bsy, dn};
  endfunction

  task automatic wait_ack(output bit seen);
    int waited;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 300) begin
      @(negedge clk);
      waited++;
      if (bus.ack != 3'b000) seen = 1'b1;
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rstN    = 1'b0;
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_outs", outs(), 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    check("post_rst_outs", outs(), 32'd0);
  endtask

  // Wait for the next ack, then check every cycle through done.
  task automatic run_packet(input int idx, input logic [PS-1:0] d, input logic [2:0] req_after,
                            input int pulse_c, input logic [2:0] pulse_v, input bit gap_chk);
    bit seen;
    wait_ack(seen);
    if (seen) begin
      if (gap_chk) check("ack_spacing", 32'(cyc - last_ack), 32'(DUR + 1));
      last_ack = cyc;
      for (int c = 0; c <= DUR; c++) begin
        if (c == 0) bus.req = req_after;
        if (c == pulse_c) bus.req = pulse_v;
        else if (c == pulse_c + 1) bus.req = req_after;
        check($sformatf("wave_g%0d_c%0d", idx, c), outs(), exp_wave(c, idx, d));
        if (c < DUR) @(negedge clk);
      end
    end
  endtask

  initial begin
    bit seen;
    rstN       = 1'b0;
    bus.req    = 3'b000;
    bus.dataIn = {4'h9, 4'h6, 4'hB};

    // Single request from requester 0, data 1011.
    do_reset();
    bus.req = 3'b001;
    run_packet(0, 4'hB, 3'b000, -1, 3'b000, 1'b0);

    // All three held: 0,1,2,0 at DUR+1 spacing.
    do_reset();
    bus.req = 3'b111;
    run_packet(0, 4'hB, 3'b111, -1, 3'b000, 1'b0);
    run_packet(1, 4'h6, 3'b111, -1, 3'b000, 1'b1);
    run_packet(2, 4'h9, 3'b111, -1, 3'b000, 1'b1);
    run_packet(0, 4'hB, 3'b000, -1, 3'b000, 1'b1);

    // Requesters 0 and 2 held: alternate, 1 never acked.
    do_reset();
    bus.req = 3'b101;
    run_packet(0, 4'hB, 3'b101, -1, 3'b000, 1'b0);
    run_packet(2, 4'h9, 3'b101, -1, 3'b000, 1'b1);
    run_packet(0, 4'hB, 3'b101, -1, 3'b000, 1'b1);
    run_packet(2, 4'h9, 3'b000, -1, 3'b000, 1'b1);

    // Reset 20 cycles into DATA, then requester 1 alone.
    do_reset();
    bus.req = 3'b001;
    wait_ack(seen);
    bus.req = 3'b000;
    repeat (60) @(negedge clk);
    check("pre_rst_bs_busy", {30'd0, bus.bsOut, bus.busy}, 32'd3);
    rstN = 1'b0;
    #1;
    check("async_rst_outs", outs(), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in_rst_outs_%0d", i), outs(), 32'd0);
    end
    rstN = 1'b1;
    @(negedge clk);
    check("after_rst_no_done", outs(), 32'd0);
    bus.req = 3'b010;
    run_packet(1, 4'h6, 3'b000, -1, 3'b000, 1'b0);

    // Requester 2 pulsed for one cycle while busy: ignored.
    bus.req = 3'b001;
    run_packet(0, 4'hB, 3'b000, 30, 3'b100, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_after_pulse_%0d", i), {28'd0, bus.ack, bus.busy}, 32'd0);
    end

`ifdef UART_SCHED_PARITY_EN
    // Parity build: data 0111 gives parity bit 1.
    do_reset();
    bus.dataIn = {4'h9, 4'h6, 4'h7};
    bus.req    = 3'b001;
    run_packet(0, 4'h7, 3'b000, -1, 3'b000, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
